// File: rtl/bcd_downcount.sv
// bcd_downcount: loadable multi-digit BCD countdown timer with start/pause/resume.
// Decrements once every TICK_DIV cycles while running, with decimal borrow across digits.
// Pulses done on reaching zero and then holds at zero until the next load.
module bcd_downcount #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done,
  output logic                  load_err
);

  localparam int W     = 4 * DIGITS;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } state_t;

  state_t             state, state_n;
  logic [W-1:0]       count_n;
  logic [DIV_W-1:0]   div, div_n;
  logic               done_n, load_err_n;
  logic [W-1:0]       dec_val;
  logic               tick;

  // True when every digit is 0..9.
  function automatic logic is_bcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Decimal decrement by one: a zero digit becomes 9 and borrows from the next one.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    logic [3:0]   d;
    r      = v;
    borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          d      = 4'd9;
          borrow = 1'b1;
        end else begin
          d      = d - 4'd1;
          borrow = 1'b0;
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  assign dec_val = bcd_dec(count);
  assign tick    = (div == DIV_W'(TICK_DIV - 1));
  assign running = (state == RUN);

  // Next-state, count, divider and pulse logic; priority is load > pause > start.
  always_comb begin
    state_n    = state;
    count_n    = count;
    div_n      = div;
    done_n     = 1'b0;
    load_err_n = 1'b0;
    if (load) begin
      if (is_bcd(load_val)) begin
        count_n = load_val;
        div_n   = '0;
        state_n = IDLE;
      end else begin
        load_err_n = 1'b1;
      end
    end else begin
      case (state)
        RUN: begin
          // The pause edge still counts as a running cycle, so a pause at P and
          // a resume at S stretch the total time by exactly S-P cycles.
          if (tick) begin
            div_n = '0;
            if (count != '0) begin
              count_n = dec_val;
              if (dec_val == '0) begin
                state_n = EXPIRED;
                done_n  = 1'b1;
              end
            end
          end else begin
            div_n = div + DIV_W'(1);
          end
          if (pause && (state_n == RUN)) state_n = PAUSED;
        end
        IDLE, PAUSED: begin
          if (!pause && start) begin
            if (count == '0) begin
              state_n = EXPIRED;
              done_n  = 1'b1;
            end else begin
              state_n = RUN;
              if (state == IDLE) div_n = '0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State, count, divider and pulse registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      div      <= '0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      div      <= div_n;
      done     <= done_n;
      load_err <= load_err_n;
    end
  end

endmodule

// File: tb/tb_bcd_downcount.sv
// tb_bcd_downcount: directed scenarios plus randomized stimulus, checked against an
// integer-valued reference model; two instances cover TICK_DIV=1 and TICK_DIV=3.
module tb_bcd_downcount;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

  logic        clk = 1'b0;
  logic        rst, load, start, pause;
  logic [15:0] load_val;
  logic [15:0] count1, count3;
  logic        running1, running3, done1, done3, err1, err3;

  int n_pass = 0;
  int n_total = 0;

  int m_val  [2];
  int m_mode [2];
  int m_ph   [2];
  bit m_done [2];
  bit m_err  [2];
  int divs   [2] = '{1, 3};

  always #5 clk = ~clk;

  bcd_downcount #(.DIGITS(4), .TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start), .pause(pause),
    .count(count1), .running(running1), .done(done1), .load_err(err1)
  );

  bcd_downcount #(.DIGITS(4), .TICK_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start), .pause(pause),
    .count(count3), .running(running3), .done(done3), .load_err(err3)
  );

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    int s, m;
    s = 0;
    m = 1;
    for (int k = 0; k < 4; k++) begin
      s = s + int'(b[4*k +: 4]) * m;
      m = m * 10;
    end
    return s;
  endfunction

  function automatic bit bcd_ok(input logic [15:0] b);
    for (int k = 0; k < 4; k++) if (b[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: remaining time as a plain integer and elapsed cycles in the current tick.
  function automatic void model_step(input int i);
    m_done[i] = 1'b0;
    m_err[i]  = 1'b0;
    if (!rst) begin
      m_val[i] = 0; m_mode[i] = M_IDLE; m_ph[i] = 0;
    end else if (load) begin
      if (bcd_ok(load_val)) begin
        m_val[i] = from_bcd(load_val); m_ph[i] = 0; m_mode[i] = M_IDLE;
      end else begin
        m_err[i] = 1'b1;
      end
    end else if (m_mode[i] == M_RUN) begin
      m_ph[i]++;
      if (m_ph[i] == divs[i]) begin
        m_ph[i] = 0;
        m_val[i]--;
        if (m_val[i] == 0) begin m_mode[i] = M_EXP; m_done[i] = 1'b1; end
      end
      if (pause && m_mode[i] == M_RUN) m_mode[i] = M_PAUSED;
    end else if (!pause && start && (m_mode[i] == M_IDLE || m_mode[i] == M_PAUSED)) begin
      if (m_val[i] == 0) begin
        m_mode[i] = M_EXP; m_done[i] = 1'b1;
      end else begin
        if (m_mode[i] == M_IDLE) m_ph[i] = 0;
        m_mode[i] = M_RUN;
      end
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; load = 1'b1; pause = 1'b1; start = 1'b1; load_val = 16'h0055;
    cycle();
    cycle();
    n_total++; if (count1 !== 16'h0000) $display("FAIL reset_count got %h want 0000", count1); else n_pass++;
    n_total++; if (running1 !== 1'b0) $display("FAIL reset_running got %b want 0", running1); else n_pass++;
    n_total++; if (done1 !== 1'b0) $display("FAIL reset_done got %b want 0", done1); else n_pass++;
    n_total++; if (err1 !== 1'b0) $display("FAIL reset_err got %b want 0", err1); else n_pass++;
    n_total++; if (count3 !== 16'h0000) $display("FAIL reset_count3 got %h want 0000", count3); else n_pass++;
    rst = 1'b1; load = 1'b0; pause = 1'b0; start = 1'b0;
    cycle();
    n_total++; if (done1 !== 1'b0 || err1 !== 1'b0) $display("FAIL post_reset_pulses got %b%b want 00", done1, err1); else n_pass++;
  endtask

  task automatic test_count12();
    int ndone;
    ndone = 0;
    load = 1'b1; load_val = 16'h0012;
    cycle();
    load = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    n_total++; if (count1 !== 16'h0012 || running1 !== 1'b1) $display("FAIL cnt12_start got %h/%b want 0012/1", count1, running1); else n_pass++;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (done1) ndone++;
      n_total++; if (count1 !== to_bcd(12 - k)) $display("FAIL cnt12_step%0d got %h want %h", k, count1, to_bcd(12 - k)); else n_pass++;
      n_total++; if (done1 !== (k == 12)) $display("FAIL cnt12_done%0d got %b want %b", k, done1, (k == 12)); else n_pass++;
    end
    cycle();
    if (done1) ndone++;
    n_total++; if (ndone !== 1) $display("FAIL cnt12_done_count got %0d want 1", ndone); else n_pass++;
    n_total++; if (running1 !== 1'b0 || count1 !== 16'h0000) $display("FAIL cnt12_hold got %h/%b want 0000/0", count1, running1); else n_pass++;
  endtask

  task automatic test_borrow();
    load = 1'b1; load_val = 16'h1000; cycle();
    load = 1'b0; start = 1'b1; cycle();
    start = 1'b0; cycle();
    n_total++; if (count1 !== 16'h0999) $display("FAIL borrow_1000 got %h want 0999", count1); else n_pass++;
    load = 1'b1; load_val = 16'h0100; cycle();
    load = 1'b0; start = 1'b1; cycle();
    start = 1'b0; cycle();
    n_total++; if (count1 !== 16'h0099) $display("FAIL borrow_0100 got %h want 0099", count1); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_total++; if (!bcd_ok(count1)) $display("FAIL borrow_digits got %h want BCD", count1); else n_pass++;
    end
  endtask

  task automatic test_invalid_load();
    load = 1'b1; load_val = 16'h0042; cycle();
    load_val = 16'h00A5; cycle();
    n_total++; if (err1 !== 1'b1) $display("FAIL inv_err got %b want 1", err1); else n_pass++;
    n_total++; if (count1 !== 16'h0042) $display("FAIL inv_count got %h want 0042", count1); else n_pass++;
    n_total++; if (running1 !== 1'b0) $display("FAIL inv_state got %b want 0", running1); else n_pass++;
    load = 1'b0; cycle();
    n_total++; if (err1 !== 1'b0) $display("FAIL inv_err_pulse got %b want 0", err1); else n_pass++;
    n_total++; if (count1 !== 16'h0042) $display("FAIL inv_count_after got %h want 0042", count1); else n_pass++;
  endtask

  task automatic test_pause();
    int done_t;
    done_t = -1;
    load = 1'b1; load_val = 16'h0005; cycle();
    load = 1'b0; start = 1'b1; cycle();
    start = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      pause = (t >= 7 && t <= 16);
      start = (t == 17);
      cycle();
      if (done3 && done_t < 0) done_t = t;
      if (t >= 7 && t <= 16) begin
        n_total++; if (count3 !== 16'h0003) $display("FAIL pause_hold_t%0d got %h want 0003", t, count3); else n_pass++;
      end
    end
    pause = 1'b0; start = 1'b0;
    n_total++; if (done_t !== 25) $display("FAIL pause_done_time got %0d want 25", done_t); else n_pass++;
    n_total++; if (count3 !== 16'h0000 || running3 !== 1'b0) $display("FAIL pause_end got %h/%b want 0000/0", count3, running3); else n_pass++;
  endtask

  task automatic test_zero_start();
    load = 1'b1; load_val = 16'h0000; cycle();
    load = 1'b0; start = 1'b1; cycle();
    n_total++; if (done1 !== 1'b1 || running1 !== 1'b0) $display("FAIL zero_start got %b/%b want 1/0", done1, running1); else n_pass++;
    start = 1'b0; cycle();
    n_total++; if (done1 !== 1'b0 || count1 !== 16'h0000) $display("FAIL zero_hold got %b/%h want 0/0000", done1, count1); else n_pass++;
    start = 1'b1; cycle();
    n_total++; if (done1 !== 1'b0 || running1 !== 1'b0) $display("FAIL zero_restart got %b/%b want 0/0", done1, running1); else n_pass++;
    load = 1'b1; load_val = 16'h0002; cycle();
    n_total++; if (running1 !== 1'b0 || count1 !== 16'h0002) $display("FAIL load_start got %b/%h want 0/0002", running1, count1); else n_pass++;
    load = 1'b0; cycle();
    n_total++; if (running1 !== 1'b1) $display("FAIL resume_run got %b want 1", running1); else n_pass++;
    start = 1'b0; cycle(); cycle();
    n_total++; if (done1 !== 1'b1 || count1 !== 16'h0000) $display("FAIL resume_done got %b/%h want 1/0000", done1, count1); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    load = 1'b1; load_val = 16'h0010; cycle();
    load = 1'b0; start = 1'b1; cycle();
    start = 1'b0; cycle(); cycle(); cycle();
    n_total++; if (count1 !== 16'h0007) $display("FAIL midrun_count got %h want 0007", count1); else n_pass++;
    rst = 1'b0; load = 1'b1; pause = 1'b1; load_val = 16'h0033; cycle();
    n_total++; if (count1 !== 16'h0000 || running1 !== 1'b0 || done1 !== 1'b0) $display("FAIL midrun_reset got %h/%b/%b want 0000/0/0", count1, running1, done1); else n_pass++;
    rst = 1'b1; load = 1'b0; pause = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(59) != 0);
      load  = ($urandom_range(11) == 0);
      pause = ($urandom_range(9) == 0);
      start = ($urandom_range(3) == 0);
      case ($urandom_range(3))
        0: load_val = to_bcd($urandom_range(19));
        1: load_val = to_bcd($urandom_range(9999));
        2: load_val = 16'($urandom);
        default: load_val = to_bcd($urandom_range(4));
      endcase
      cycle();
      n_total++; if (count1 !== to_bcd(m_val[0])) $display("FAIL rnd_count1 n=%0d got %h want %h", n, count1, to_bcd(m_val[0])); else n_pass++;
      n_total++; if (running1 !== (m_mode[0] == M_RUN)) $display("FAIL rnd_run1 n=%0d got %b want %b", n, running1, (m_mode[0] == M_RUN)); else n_pass++;
      n_total++; if (done1 !== m_done[0] || err1 !== m_err[0]) $display("FAIL rnd_pulse1 n=%0d got %b%b want %b%b", n, done1, err1, m_done[0], m_err[0]); else n_pass++;
      n_total++; if (count3 !== to_bcd(m_val[1])) $display("FAIL rnd_count3 n=%0d got %h want %h", n, count3, to_bcd(m_val[1])); else n_pass++;
      n_total++; if (running3 !== (m_mode[1] == M_RUN)) $display("FAIL rnd_run3 n=%0d got %b want %b", n, running3, (m_mode[1] == M_RUN)); else n_pass++;
      n_total++; if (done3 !== m_done[1] || err3 !== m_err[1]) $display("FAIL rnd_pulse3 n=%0d got %b%b want %b%b", n, done3, err3, m_done[1], m_err[1]); else n_pass++;
    end
    rst = 1'b1; load = 1'b0; pause = 1'b0; start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; load_val = '0;
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 0; m_mode[i] = M_IDLE; m_ph[i] = 0; m_done[i] = 1'b0; m_err[i] = 1'b0;
    end
    #2;
    test_reset();
    test_count12();
    test_borrow();
    test_invalid_load();
    test_pause();
    test_zero_start();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
